// File: rtl/geofence_point_test.sv
// Last stage of the geo-fencing pipeline. It captures N_VERT ordered fence vertices and one
// query point, then tests one edge cross-product per cycle to decide strict containment.
module geofence_point_test #(
  parameter int N_VERT = 6,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] vX,
  input  logic [W-1:0] vY,
  input  logic         pt_valid,
  input  logic [W-1:0] ptX,
  input  logic [W-1:0] ptY,
  output logic         busy,
  output logic         out_valid,
  output logic         is_inside
);

  localparam int KW  = (N_VERT > 1) ? $clog2(N_VERT) : 1;
  localparam int CW  = $clog2(N_VERT + 1);
  localparam int CPW = 2 * W + 3;

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  // Cross product (b - a) x (p - a). The operands are zero-extended coordinates, so each
  // difference fits in W+1 signed bits and the result fits in 2W+3 bits.
  function automatic logic signed [CPW-1:0] edge_cross(
    input logic [W-1:0] ax, input logic [W-1:0] ay,
    input logic [W-1:0] bx, input logic [W-1:0] by,
    input logic [W-1:0] px, input logic [W-1:0] py
  );
    logic signed [W:0]     ex, ey, dx, dy;
    logic signed [CPW-1:0] exw, eyw, dxw, dyw;
    ex  = $signed({1'b0, bx}) - $signed({1'b0, ax});
    ey  = $signed({1'b0, by}) - $signed({1'b0, ay});
    dx  = $signed({1'b0, px}) - $signed({1'b0, ax});
    dy  = $signed({1'b0, py}) - $signed({1'b0, ay});
    exw = CPW'(ex);
    eyw = CPW'(ey);
    dxw = CPW'(dx);
    dyw = CPW'(dy);
    return exw * dyw - eyw * dxw;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  vcnt_q, vcnt_d;
  logic [KW-1:0]  k_q, k_d, kn;
  logic           pt_ok_q, pt_ok_d;
  logic           pos_q, pos_d, neg_q, neg_d;
  logic           out_valid_q, out_valid_d;
  logic           is_inside_q, is_inside_d;
  logic           vwr, ptwr;

  logic [W-1:0]   vx_q [N_VERT];
  logic [W-1:0]   vy_q [N_VERT];
  logic [W-1:0]   ptx_q, pty_q;

  logic signed [CPW-1:0] cval;
  logic                  c_neg, c_zero;

  assign kn     = (k_q == KW'(N_VERT - 1)) ? '0 : k_q + KW'(1);
  assign cval   = edge_cross(vx_q[k_q], vy_q[k_q], vx_q[kn], vy_q[kn], ptx_q, pty_q);
  assign c_neg  = cval[CPW-1];
  assign c_zero = (cval == '0);

  always_comb begin
    state_d     = state_q;
    vcnt_d      = vcnt_q;
    pt_ok_d     = pt_ok_q;
    k_d         = k_q;
    pos_d       = pos_q;
    neg_d       = neg_q;
    out_valid_d = 1'b0;
    is_inside_d = is_inside_q;
    vwr         = 1'b0;
    ptwr        = 1'b0;
    case (state_q)
      LOAD: begin
        vwr = in_valid && (vcnt_q < CW'(N_VERT));
        if (vwr) vcnt_d = vcnt_q + CW'(1);
        if (pt_valid) begin
          ptwr    = 1'b1;
          pt_ok_d = 1'b1;
        end
        // The beat that completes the set starts the calculation on its own edge.
        if ((vcnt_d == CW'(N_VERT)) && pt_ok_d) begin
          state_d = CALC;
          k_d     = '0;
        end
      end
      CALC: begin
        // A zero cross product marks both flags so an on-edge point reads as outside.
        pos_d = pos_q | ~c_neg;
        neg_d = neg_q | c_neg | c_zero;
        if (k_q == KW'(N_VERT - 1)) state_d = DONE;
        else                        k_d     = k_q + KW'(1);
      end
      DONE: begin
        out_valid_d = 1'b1;
        is_inside_d = pos_q ^ neg_q;
        vcnt_d      = '0;
        pt_ok_d     = 1'b0;
        pos_d       = 1'b0;
        neg_d       = 1'b0;
        k_d         = '0;
        state_d     = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      vcnt_q      <= '0;
      pt_ok_q     <= 1'b0;
      k_q         <= '0;
      pos_q       <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      is_inside_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vcnt_q      <= vcnt_d;
      pt_ok_q     <= pt_ok_d;
      k_q         <= k_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      is_inside_q <= is_inside_d;
    end
  end

  // Coordinate storage carries no reset; the counters and flags decide what is valid.
  always_ff @(posedge clk) begin
    if (vwr) begin
      vx_q[vcnt_q[KW-1:0]] <= vX;
      vy_q[vcnt_q[KW-1:0]] <= vY;
    end
    if (ptwr) begin
      ptx_q <= ptX;
      pty_q <= ptY;
    end
  end

  assign busy      = (state_q != LOAD);
  assign out_valid = out_valid_q;
  assign is_inside = is_inside_q;

endmodule

// File: tb/tb_geofence_point_test.sv
// Bench for geofence_point_test: directed fence and point sets. An event-level model is
// compared against the DUT on every cycle, and literal results pin each case.
module tb_geofence_point_test;

  localparam int NV = 6;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, pt_valid = 1'b0;
  logic [W-1:0] vX = '0, vY = '0, ptX = '0, ptY = '0;
  logic         busy, out_valid, is_inside;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  geofence_point_test #(.N_VERT(NV), .W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .vX(vX), .vY(vY),
    .pt_valid(pt_valid), .ptX(ptX), .ptY(ptY),
    .busy(busy), .out_valid(out_valid), .is_inside(is_inside)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Event-level model: gather a complete set, decide containment from the geometry,
  // and then stay unavailable for NV+1 edges, with the result appearing on the last one.
  bit m_live = 0;
  int m_n = 0, m_ptok = 0, m_busy = 0;
  bit m_res = 0, e_ov = 0, e_in = 0;
  int mx[NV], my[NV];
  int mpx = 0, mpy = 0;

  function automatic bit model_inside();
    int npos = 0, nneg = 0;
    for (int k = 0; k < NV; k++) begin
      int a = k;
      int b = (k + 1) % NV;
      int c = (mx[b] - mx[a]) * (mpy - my[a]) - (my[b] - my[a]) * (mpx - mx[a]);
      if (c > 0) npos++;
      if (c < 0) nneg++;
    end
    return (npos == NV) || (nneg == NV);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_n = 0; m_ptok = 0; m_busy = 0; e_ov = 0; e_in = 0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      e_ov   = (m_busy == 0);
      if (m_busy == 0) e_in = m_res;
    end else begin
      e_ov = 0;
      if (in_valid && m_n < NV) begin
        mx[m_n] = int'(vX); my[m_n] = int'(vY); m_n++;
      end
      if (pt_valid) begin
        mpx = int'(ptX); mpy = int'(ptY); m_ptok = 1;
      end
      if (m_n == NV && m_ptok == 1) begin
        m_res = model_inside(); m_busy = NV + 1; m_n = 0; m_ptok = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy > 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      chk("is_inside", {31'd0, is_inside}, {31'd0, e_in});
    end
  end

  task automatic set_in(input bit iv, input int x, input int y, input bit pv, input int px, input int py);
    in_valid = iv; vX = W'(x); vY = W'(y);
    pt_valid = pv; ptX = W'(px); ptY = W'(py);
  endtask

  task automatic beat(input bit iv, input int x, input int y, input bit pv, input int px, input int py);
    @(negedge clk);
    set_in(iv, x, y, pv, px, py);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 0, 0, 0);
  endtask

  // Called right after the last required input is driven; the strobe must come 7 edges later.
  task automatic wait_strobe(input string nm, input bit exp_in, input bit inject);
    int n = 0, nb = 0;
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inject && busy) set_in(1, 99, 99, 1, 1, 1);
      else                set_in(0, 0, 0, 0, 0, 0);
      if (busy) nb++;
      if (out_valid) begin got = 1; break; end
      n++;
    end
    chk({nm, " strobe"}, {31'd0, got}, 32'd1);
    chk({nm, " latency"}, n, 32'd7);
    chk({nm, " busy cycles"}, nb, 32'd7);
    chk({nm, " result"}, {31'd0, is_inside}, {31'd0, exp_in});
  endtask

  int hx[NV] = '{20, 30, 40, 30, 20, 10};
  int hy[NV] = '{10, 10, 20, 30, 30, 20};
  int ex[NV] = '{0, 128, 255, 255, 128, 0};
  int ey[NV] = '{0, 0, 128, 255, 255, 128};

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset is_inside", {31'd0, is_inside}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Inside point, supplied alongside the final vertex.
    for (int i = 0; i < NV; i++) beat(1, hx[i], hy[i], i == NV - 1, 25, 20);
    wait_strobe("c1", 1'b1, 1'b0);
    idle(2);

    // The point is overwritten by a later one: the outside point is the one that counts.
    for (int i = 0; i < NV; i++)
      beat(1, hx[i], hy[i], (i == 0) || (i == NV - 1), (i == 0) ? 25 : 50, (i == 0) ? 20 : 50);
    wait_strobe("c2 outside", 1'b0, 1'b0);
    idle(2);

    // A point lying on the first edge.
    for (int i = 0; i < NV; i++) beat(1, hx[i], hy[i], i == NV - 1, 25, 10);
    wait_strobe("c2 on-edge", 1'b0, 1'b0);
    idle(2);

    // Clockwise order, with the point arriving three idle cycles after the last vertex.
    for (int i = 0; i < NV; i++) beat(1, hx[NV - 1 - i], hy[NV - 1 - i], 0, 0, 0);
    idle(3);
    beat(0, 0, 0, 1, 25, 20);
    wait_strobe("c3 cw", 1'b1, 1'b0);
    idle(2);

    // Extreme coordinates give the largest cross products.
    for (int i = 0; i < NV; i++) beat(1, ex[i], ey[i], i == NV - 1, 128, 128);
    wait_strobe("c4 extremes", 1'b1, 1'b0);
    idle(2);

    // Reset partway through loading discards the partial set.
    for (int i = 0; i < 3; i++) beat(1, 200, 200, 1, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("c5 reset clears is_inside", {31'd0, is_inside}, 32'd0);
    for (int i = 0; i < NV; i++) beat(1, hx[i], hy[i], i == NV - 1, 25, 20);
    wait_strobe("c5 after reset", 1'b1, 1'b0);
    idle(2);

    // A seventh vertex is dropped, and beats arriving while busy are ignored.
    for (int i = 0; i < NV; i++) beat(1, hx[i], hy[i], 0, 0, 0);
    beat(1, 200, 200, 0, 0, 0);
    beat(0, 0, 0, 1, 25, 20);
    wait_strobe("c6 extra beats", 1'b1, 1'b1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miss);
    $fatal(1, "time limit");
  end

endmodule
